// File: rtl/osc_pkg.sv
// osc_pkg: shared types, constants and helpers for the oscillator clock-enable generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   OSC_FREQ_HZ  nominal on-chip RC oscillator frequency
//   OSC_NUM_CH   default channel count
//   OSC_DIV_W    default divisor/counter width
//   div_t        divisor type at the default width
//   ch_idx_t     channel index type at the default channel count
//   hz_to_div()  divisor for a wanted enable rate, saturated to the divisor width
package osc_pkg;

    localparam int OSC_FREQ_HZ = 50_000_000;
    localparam int OSC_NUM_CH  = 4;
    localparam int OSC_DIV_W   = 16;

    typedef logic [OSC_DIV_W-1:0]          div_t;
    typedef logic [$clog2(OSC_NUM_CH)-1:0] ch_idx_t;

    // A zero target rate or a quotient too large for the counter both return
    // the largest representable divisor (slowest possible enable rate).
    function automatic div_t hz_to_div(input int unsigned target_hz);
        int unsigned q;
        if (target_hz == 0) begin
            return '1;
        end
        q = OSC_FREQ_HZ / target_hz;
        if ((q >> OSC_DIV_W) != 0) begin
            return '1;
        end
        return div_t'(q);
    endfunction

endpackage

// File: rtl/osc_clken_chan.sv
// osc_clken_chan: one programmable divider channel producing single-cycle enable pulses.
// Latency: ce registered; it rises D edges after the edge that restarts the counter.
// Backpressure: none; pulses are strobes with no handshake.
//
// Optional feature macro: OSC_TOGGLE_OUT_EN (builds the square-wave toggle flop).
//
// Ports:
//   i_clk     oscillator clock
//   i_rst     synchronous active-high reset
//   i_run     channel may count (oscillator settled)
//   i_sync    restart counter, suppress the pulse that this cycle would launch, clear toggle
//   i_wr      load i_wr_div into the divisor register and restart the counter
//   i_wr_div  new divisor value
//   o_ce      one-cycle enable pulse, period = divisor
//   o_tgl     50%-duty square wave, period = 2 * divisor (0 when the feature is absent)
module osc_clken_chan
    import osc_pkg::*;
#(
    parameter int               DIV_W       = OSC_DIV_W,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [DIV_W-1:0] i_wr_div,
    output logic             o_ce,
    output logic             o_tgl
);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             r_ce;

    logic [DIV_W-1:0] w_div_m1;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic             w_off;
    logic             w_at_end;

    // D-1 only matters when D is non-zero; D=0 is caught by w_off so the
    // wrapped all-ones value is never used as a terminal count.
    assign w_div_m1 = r_div - 1'b1;
    assign w_off    = (r_div == '0);
    assign w_at_end = !w_off && (r_cnt == w_div_m1);

    always_comb begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (!i_run || i_sync || i_wr || w_off || w_at_end) begin
            w_cnt_nxt = '0;
        end
    end

    // The pulse launched at this edge is judged on the old divisor, so a
    // write never swallows a pulse that was already due; sync does.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div <= DEFAULT_DIV;
            r_cnt <= '0;
            r_ce  <= 1'b0;
        end else begin
            if (i_wr) begin
                r_div <= i_wr_div;
            end
            r_cnt <= w_cnt_nxt;
            r_ce  <= i_run && w_at_end && !i_sync;
        end
    end

    assign o_ce = r_ce;

`ifdef OSC_TOGGLE_OUT_EN
    logic r_tgl;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tgl <= 1'b0;
        end else if (i_sync) begin
            r_tgl <= 1'b0;
        end else if (r_ce) begin
            r_tgl <= ~r_tgl;
        end
    end

    assign o_tgl = r_tgl;
`else
    assign o_tgl = 1'b0;
`endif

endmodule

// File: rtl/osc_clken_gen.sv
// osc_clken_gen: multi-channel clock-enable generator on the free-running RC oscillator clock.
// Latency: all outputs registered; osc_ready after STARTUP_CYCLES, ce D edges after (re)start.
// Backpressure: none; writes and sync are single-cycle strobes that are always accepted.
//
// Optional feature macro: OSC_TOGGLE_OUT_EN (per-channel square-wave outputs on tgl_out).
//
// Ports:
//   clk        oscillator clock (single domain)
//   rst        synchronous active-high reset
//   wr_en      divisor write strobe
//   wr_ch      channel index for the write; indices >= NUM_CH are ignored
//   wr_div     new divisor (0 turns the channel off)
//   sync       restart every channel counter on this edge
//   osc_ready  high once the startup settle time has elapsed
//   ce         per-channel single-cycle enable pulses
//   tgl_out    per-channel square waves (tied low without OSC_TOGGLE_OUT_EN)
module osc_clken_gen
    import osc_pkg::*;
#(
    parameter  int FREQUENCY_HZ   = OSC_FREQ_HZ,
    parameter  int NUM_CH         = OSC_NUM_CH,
    parameter  int DIV_W          = OSC_DIV_W,
    parameter  int STARTUP_CYCLES = 1024,
    parameter  int DEFAULT_DIV    = 0,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DIV_W-1:0]  wr_div,
    input  logic              sync,
    output logic              osc_ready,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] tgl_out
);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("osc_clken_gen: NUM_CH must be 1..16");
    end
    if (STARTUP_CYCLES < 1) begin : g_bad_startup
        $error("osc_clken_gen: STARTUP_CYCLES must be >= 1");
    end
    if (FREQUENCY_HZ <= 0) begin : g_bad_freq
        $error("osc_clken_gen: FREQUENCY_HZ must be positive");
    end

    localparam int            SW      = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam logic [SW-1:0] ST_LAST = SW'(STARTUP_CYCLES - 1);
    // osc_ready is a flop, so it is set one count early to be high in the
    // cycle where the counter shows STARTUP_CYCLES-1. With a single settle
    // cycle it can only rise in the cycle after reset.
    localparam logic [SW-1:0] ST_RISE = (STARTUP_CYCLES > 1) ? SW'(STARTUP_CYCLES - 2) : '0;

    logic [SW-1:0]     r_st_cnt;
    logic              r_ready;
    logic [NUM_CH-1:0] w_wr_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st_cnt <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (r_st_cnt != ST_LAST) begin
                r_st_cnt <= r_st_cnt + 1'b1;
            end
            if (r_st_cnt == ST_RISE) begin
                r_ready <= 1'b1;
            end
        end
    end

    assign osc_ready = r_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // An out-of-range wr_ch matches no channel, so the write is dropped.
        assign w_wr_hit[i] = wr_en && (wr_ch == CH_W'(i));

        osc_clken_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DIV_W'(DEFAULT_DIV))
        ) u_chan (
            .i_clk    (clk),
            .i_rst    (rst),
            .i_run    (r_ready),
            .i_sync   (sync),
            .i_wr     (w_wr_hit[i]),
            .i_wr_div (wr_div),
            .o_ce     (ce[i]),
            .o_tgl    (tgl_out[i])
        );
    end

endmodule

// File: tb/tb_osc_clken_gen.sv
module tb_osc_clken_gen;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int ST  = 16;

    logic           clk    = 1'b0;
    logic           rst    = 1'b1;
    logic           wr_en  = 1'b0;
    logic [1:0]     wr_ch  = '0;
    logic [DW-1:0]  wr_div = '0;
    logic           sync   = 1'b0;
    logic           osc_ready;
    logic [NCH-1:0] ce;
    logic [NCH-1:0] tgl_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    osc_clken_gen #(
        .FREQUENCY_HZ   (50_000_000),
        .NUM_CH         (NCH),
        .DIV_W          (DW),
        .STARTUP_CYCLES (ST),
        .DEFAULT_DIV    (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_div    (wr_div),
        .sync      (sync),
        .osc_ready (osc_ready),
        .ce        (ce),
        .tgl_out   (tgl_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; outputs are stable here and
    // inputs set here are sampled by the following edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle strobe of sync and/or a divisor write; returns just after the
    // edge that sampled it (that cycle is +0 for the expected pulse times).
    task automatic strobe(input logic s, input logic w, input int ch, input int d);
        sync   = s;
        wr_en  = w;
        wr_ch  = 2'(ch);
        wr_div = DW'(d);
        step();
        sync   = 1'b0;
        wr_en  = 1'b0;
    endtask

    // Called in the first cycle after the reset edge; ends in the ready cycle.
    task automatic startup(input string tag);
        for (int k = 0; k < ST; k++) begin
            check($sformatf("%s_ready k=%0d", tag, k), osc_ready, (k == ST - 1) ? 1 : 0);
            check($sformatf("%s_ce k=%0d", tag, k), ce, 0);
            check($sformatf("%s_tgl k=%0d", tag, k), tgl_out, 0);
            if (k < ST - 1) step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] exp_ce;
        int         exp_t;

        // 1: reset and startup hold-off.
        repeat (3) step();
        check("rst_ready", osc_ready, 0);
        check("rst_ce", ce, 0);
        rst = 1'b0;
        startup("t1");

        // 2: ch0 D=5, other channels silent at DEFAULT_DIV=0.
        strobe(1'b0, 1'b1, 0, 5);
        check("t2_ce j=0", ce, 0);
        for (int j = 1; j <= 12; j++) begin
            step();
            check($sformatf("t2_ce j=%0d", j), ce, (j % 5 == 0) ? 4'b0001 : 4'b0000);
        end

        // 3: ch1 D=1 runs continuously, then D=0 silences it after the in-flight pulse.
        strobe(1'b0, 1'b1, 1, 1);
        check("t3_ce1 j=0", ce[1], 0);
        for (int j = 1; j <= 5; j++) begin
            step();
            check($sformatf("t3_ce1_on j=%0d", j), ce[1], 1);
        end
        strobe(1'b0, 1'b1, 1, 0);
        check("t3_ce1_inflight", ce[1], 1);
        for (int j = 1; j <= 10; j++) begin
            step();
            check($sformatf("t3_ce1_off j=%0d", j), ce[1], 0);
        end

        // 4: ch0 D=4 and ch2 D=6 out of phase; sync lands where ch0 would fire.
        strobe(1'b0, 1'b1, 0, 4);
        step();
        step();
        strobe(1'b0, 1'b1, 2, 6);
        repeat (4) step();
        strobe(1'b1, 1'b0, 0, 0);
        check("t4_sync_suppress", ce, 0);
        for (int j = 1; j <= 12; j++) begin
            step();
            exp_ce = {1'b0, (j % 6 == 0), 1'b0, (j % 4 == 0)};
            check($sformatf("t4_ce j=%0d", j), ce, exp_ce);
        end

        // 5: write ch3 D=3 together with sync while ch0 D=5 and ch2 D=6 run.
        strobe(1'b0, 1'b1, 0, 5);
        step();
        step();
        strobe(1'b1, 1'b1, 3, 3);
        check("t5_ce j=0", ce, 0);
        for (int j = 1; j <= 12; j++) begin
            step();
            exp_ce = {(j % 3 == 0), (j % 6 == 0), 1'b0, (j % 5 == 0)};
            check($sformatf("t5_ce j=%0d", j), ce, exp_ce);
        end
        check("t5_ready_held", osc_ready, 1);

        // 7: toggle output on ch0 with D=3, started from a sync so it begins at 0.
        strobe(1'b1, 1'b1, 0, 3);
        check("t7_tgl j=0", tgl_out, 0);
        for (int j = 1; j <= 12; j++) begin
            step();
`ifdef OSC_TOGGLE_OUT_EN
            exp_t = ((j - 1) / 3) % 2;
`else
            exp_t = 0;
`endif
            check($sformatf("t7_ce0 j=%0d", j), ce[0], (j % 3 == 0) ? 1 : 0);
            check($sformatf("t7_tgl0 j=%0d", j), tgl_out[0], exp_t);
        end

        // 6: reset just before a due ch0 D=7 pulse; startup re-runs, divisors return to 0.
        strobe(1'b0, 1'b1, 0, 7);
        repeat (6) step();
        rst = 1'b1;
        step();
        check("t6_ce_after_rst", ce, 0);
        check("t6_ready_after_rst", osc_ready, 0);
        check("t6_tgl_after_rst", tgl_out, 0);
        rst = 1'b0;
        startup("t6");
        for (int j = 1; j <= 12; j++) begin
            step();
            check($sformatf("t6_ce_default j=%0d", j), ce, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
